// File: rtl/goose_motion_ctrl.sv
// Per-frame goose motion/animation sequencer: vertical position and sprite select for the runner game.
// Optional GOOSE_FASTFALL_EN: btn_slide cuts the rise short and doubles the fall step while airborne.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | game stopped, goose parked on the ground
// RUN       | running, run-cycle animation, accepts requests
// JUMP_UP   | rising JUMP_STEP per frame for JUMP_FRAMES frames
// JUMP_DOWN | falling back, clamped at GROUND_Y
// SLIDE     | slide pose for SLIDE_FRAMES frames
// DEAD      | collision seen, outputs frozen until game_run drops
module goose_motion_ctrl #(
   parameter int GROUND_Y     = 400,
   parameter int JUMP_STEP    = 6,
   parameter int JUMP_FRAMES  = 15,
   parameter int SLIDE_FRAMES = 30,
   parameter int ANIM_FRAMES  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       game_run,
   input  logic       btn_jump,
   input  logic       btn_slide,
   input  logic       collision,
   output logic [9:0] goose_y,
   output logic [1:0] sprite_sel,
   output logic       airborne,
   output logic       dead
);
   localparam int RW = $clog2(JUMP_FRAMES) + 1;
   localparam int SW = $clog2(SLIDE_FRAMES) + 1;
   localparam int AW = $clog2(ANIM_FRAMES) + 1;
   localparam logic [9:0]    GROUND     = 10'(GROUND_Y);
   localparam logic [9:0]    STEP       = 10'(JUMP_STEP);
   localparam logic [9:0]    STEP2      = 10'(2 * JUMP_STEP);
   localparam logic [RW-1:0] RISE_LAST  = RW'(JUMP_FRAMES - 1);
   localparam logic [SW-1:0] SLIDE_LAST = SW'(SLIDE_FRAMES - 1);
   localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_FRAMES - 1);
   localparam logic [1:0] SPR_RUN_A = 2'd0;
   localparam logic [1:0] SPR_RUN_B = 2'd1;
   localparam logic [1:0] SPR_JUMP  = 2'd2;
   localparam logic [1:0] SPR_SLIDE = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_JUMP_UP, S_JUMP_DOWN, S_SLIDE, S_DEAD
   } state_t;

   state_t        state_q, state_d;
   logic [9:0]    y_q, y_d;
   logic [1:0]    sel_q, sel_d;
   logic          air_q, air_d, dead_q, dead_d;
   logic [AW-1:0] anim_q, anim_d;
   logic [RW-1:0] rise_q, rise_d;
   logic [SW-1:0] slide_q, slide_d;
   logic          jump_pend_q, jump_pend_d, slide_pend_q, slide_pend_d;
   logic          jump_prev_q, slide_prev_q;
   logic          jump_rise, slide_rise, active, fastfall;
   logic [10:0]   fall_sum;

`ifdef GOOSE_FASTFALL_EN
   assign fastfall = btn_slide;
`else
   assign fastfall = 1'b0;
`endif

   assign jump_rise  = btn_jump & ~jump_prev_q;
   assign slide_rise = btn_slide & ~slide_prev_q;
   assign active     = (state_q == S_RUN) || (state_q == S_JUMP_UP) ||
                       (state_q == S_JUMP_DOWN) || (state_q == S_SLIDE);
   // 11-bit sum so the landing compare cannot wrap
   assign fall_sum   = {1'b0, y_q} + {1'b0, (fastfall ? STEP2 : STEP)};

   always_comb begin
      state_d      = state_q;
      y_d          = y_q;
      sel_d        = sel_q;
      anim_d       = anim_q;
      rise_d       = rise_q;
      slide_d      = slide_q;
      jump_pend_d  = 1'b0;
      slide_pend_d = 1'b0;
      if (active && collision) begin
         state_d = S_DEAD;
      end else if (active && !game_run) begin
         state_d = S_IDLE;
         y_d     = GROUND;
         sel_d   = SPR_RUN_A;
      end else begin
         case (state_q)
            S_IDLE: begin
               y_d   = GROUND;
               sel_d = SPR_RUN_A;
               if (frame_tick && game_run) begin
                  state_d = S_RUN;
                  anim_d  = '0;
               end
            end
            S_RUN: begin
               if (frame_tick && jump_pend_q) begin
                  state_d = S_JUMP_UP;
                  sel_d   = SPR_JUMP;
                  rise_d  = '0;
               end else if (frame_tick && slide_pend_q) begin
                  state_d = S_SLIDE;
                  sel_d   = SPR_SLIDE;
                  slide_d = '0;
               end else if (frame_tick) begin
                  if (anim_q == ANIM_LAST) begin
                     anim_d = '0;
                     sel_d  = (sel_q == SPR_RUN_A) ? SPR_RUN_B : SPR_RUN_A;
                  end else begin
                     anim_d = anim_q + 1'b1;
                  end
               end
            end
            S_JUMP_UP: begin
               if (frame_tick && fastfall) begin
                  state_d = S_JUMP_DOWN;
               end else if (frame_tick) begin
                  y_d = y_q - STEP;
                  if (rise_q == RISE_LAST) state_d = S_JUMP_DOWN;
                  else                     rise_d  = rise_q + 1'b1;
               end
            end
            S_JUMP_DOWN: begin
               if (frame_tick) begin
                  if (fall_sum >= {1'b0, GROUND}) begin
                     y_d     = GROUND;
                     state_d = S_RUN;
                     sel_d   = SPR_RUN_A;
                     anim_d  = '0;
                  end else begin
                     y_d = fall_sum[9:0];
                  end
               end
            end
            S_SLIDE: begin
               y_d = GROUND;
               if (frame_tick) begin
                  if (slide_q == SLIDE_LAST) begin
                     state_d = S_RUN;
                     sel_d   = SPR_RUN_A;
                     anim_d  = '0;
                  end else begin
                     slide_d = slide_q + 1'b1;
                  end
               end
            end
            S_DEAD: begin
               if (!game_run) begin
                  state_d = S_IDLE;
                  y_d     = GROUND;
                  sel_d   = SPR_RUN_A;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      // requests survive only while staying in RUN; anything leaving RUN drops them
      if (state_q == S_RUN && state_d == S_RUN) begin
         jump_pend_d  = jump_pend_q | jump_rise;
         slide_pend_d = slide_pend_q | slide_rise;
      end
      air_d  = (state_d == S_JUMP_UP) || (state_d == S_JUMP_DOWN);
      dead_d = (state_d == S_DEAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         y_q          <= GROUND;
         sel_q        <= SPR_RUN_A;
         air_q        <= 1'b0;
         dead_q       <= 1'b0;
         anim_q       <= '0;
         rise_q       <= '0;
         slide_q      <= '0;
         jump_pend_q  <= 1'b0;
         slide_pend_q <= 1'b0;
         jump_prev_q  <= 1'b0;
         slide_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         y_q          <= y_d;
         sel_q        <= sel_d;
         air_q        <= air_d;
         dead_q       <= dead_d;
         anim_q       <= anim_d;
         rise_q       <= rise_d;
         slide_q      <= slide_d;
         jump_pend_q  <= jump_pend_d;
         slide_pend_q <= slide_pend_d;
         jump_prev_q  <= btn_jump;
         slide_prev_q <= btn_slide;
      end
   end

   assign goose_y    = y_q;
   assign sprite_sel = sel_q;
   assign airborne   = air_q;
   assign dead       = dead_q;
endmodule

// File: tb/tb_goose_motion_ctrl.sv
// Self-checking bench for goose_motion_ctrl: expected outputs queued per driven cycle, popped after the edge.
module tb_goose_motion_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0, game_run = 1'b0;
   logic       btn_jump = 1'b0, btn_slide = 1'b0, collision = 1'b0;
   logic [9:0] goose_y;
   logic [1:0] sprite_sel;
   logic       airborne, dead;

   typedef struct packed {
      logic [9:0] y;
      logic [1:0] sel;
      logic       air;
      logic       dead;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   goose_motion_ctrl dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_run(game_run),
      .btn_jump(btn_jump), .btn_slide(btn_slide), .collision(collision),
      .goose_y(goose_y), .sprite_sel(sprite_sel), .airborne(airborne), .dead(dead)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(int y, int sel, int air, int dd);
      exp_t e;
      e.y = 10'(y); e.sel = 2'(sel); e.air = 1'(air); e.dead = 1'(dd);
      return e;
   endfunction

   task automatic chk(input string tag, input exp_t act, input exp_t exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got y=%0d sel=%0d air=%0d dead=%0d, want y=%0d sel=%0d air=%0d dead=%0d",
                  tag, act.y, act.sel, act.air, act.dead, exp.y, exp.sel, exp.air, exp.dead);
      end
   endtask

   // one clock with optional frame_tick; expectation queued at drive, compared after the edge
   task automatic cyc(input string tag, input bit tick, input exp_t e);
      exp_t want;
      sb.push_back(e);
      frame_tick = tick;
      @(negedge clk);
      frame_tick = 1'b0;
      want = sb.pop_front();
      chk(tag, {goose_y, sprite_sel, airborne, dead}, want);
   endtask

   task automatic press(input bit j, input bit s);
      btn_jump = j; btn_slide = s;
      @(negedge clk);
      btn_jump = 1'b0; btn_slide = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset", {goose_y, sprite_sel, airborne, dead}, mk(400, 0, 0, 0));
      rst_n = 1'b1;
      @(negedge clk);
      cyc("idle_no_run", 1, mk(400, 0, 0, 0));

      game_run = 1'b1;
      cyc("enter_run", 1, mk(400, 0, 0, 0));
      for (int k = 1; k <= 16; k++)
         cyc($sformatf("anim%0d", k), 1, mk(400, (k >= 8 && k < 16) ? 1 : 0, 0, 0));

      press(1, 0);
      cyc("jump_start", 1, mk(400, 2, 1, 0));
      for (int k = 1; k <= 15; k++) cyc($sformatf("rise%0d", k), 1, mk(400 - 6 * k, 2, 1, 0));
      for (int k = 1; k <= 14; k++) cyc($sformatf("fall%0d", k), 1, mk(310 + 6 * k, 2, 1, 0));
      cyc("land", 1, mk(400, 0, 0, 0));

      press(1, 1);
      cyc("both_jump", 1, mk(400, 2, 1, 0));
      cyc("both_rise1", 1, mk(394, 2, 1, 0));
      press(0, 1);
      for (int k = 2; k <= 15; k++) cyc($sformatf("b_rise%0d", k), 1, mk(400 - 6 * k, 2, 1, 0));
      for (int k = 1; k <= 14; k++) cyc($sformatf("b_fall%0d", k), 1, mk(310 + 6 * k, 2, 1, 0));
      cyc("b_land", 1, mk(400, 0, 0, 0));
      cyc("slide_dropped", 1, mk(400, 0, 0, 0));

      press(0, 1);
      cyc("slide_start", 1, mk(400, 3, 0, 0));
      for (int k = 1; k <= 29; k++) cyc($sformatf("slide%0d", k), 1, mk(400, 3, 0, 0));
      cyc("slide_end", 1, mk(400, 0, 0, 0));

      press(1, 0);
      cyc("cj_start", 1, mk(400, 2, 1, 0));
      for (int k = 1; k <= 10; k++) cyc($sformatf("cj_rise%0d", k), 1, mk(400 - 6 * k, 2, 1, 0));
      collision = 1'b1;
      cyc("collide", 0, mk(340, 2, 0, 1));
      collision = 1'b0;
      cyc("dead_hold_tick", 1, mk(340, 2, 0, 1));
      game_run = 1'b0;
      cyc("dead_to_idle", 0, mk(400, 0, 0, 0));

      game_run = 1'b1;
      cyc("rerun", 1, mk(400, 0, 0, 0));
      press(1, 0);
      game_run = 1'b0;
      cyc("stop_run", 0, mk(400, 0, 0, 0));
      game_run = 1'b1;
      cyc("rerun2", 1, mk(400, 0, 0, 0));
      cyc("pend_cleared", 1, mk(400, 0, 0, 0));

      collision = 1'b1; game_run = 1'b0;
      cyc("coll_over_stop", 0, mk(400, 0, 0, 1));
      collision = 1'b0;
      cyc("dead_release", 0, mk(400, 0, 0, 0));

      game_run = 1'b1;
      cyc("ff_run", 1, mk(400, 0, 0, 0));
      press(1, 0);
      cyc("ff_jump", 1, mk(400, 2, 1, 0));
      for (int k = 1; k <= 5; k++) cyc($sformatf("ff_rise%0d", k), 1, mk(400 - 6 * k, 2, 1, 0));
      btn_slide = 1'b1;
`ifdef GOOSE_FASTFALL_EN
      cyc("ff_cut", 1, mk(370, 2, 1, 0));
      cyc("ff_fall1", 1, mk(382, 2, 1, 0));
      cyc("ff_fall2", 1, mk(394, 2, 1, 0));
      cyc("ff_land", 1, mk(400, 0, 0, 0));
`else
      cyc("noff_rise6", 1, mk(364, 2, 1, 0));
      cyc("noff_rise7", 1, mk(358, 2, 1, 0));
`endif
      btn_slide = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
